ulpi_packetizer: RTL and testbench

Frames the ULPI receive stream into length-prefixed packets for the host link. Sits between the ULPI PHY interface (consumes its DATA/RXCMD/VALID byte stream) and the USB FIFO streamer (drives its data/wr inputs and obeys have_space). Payload bytes are buffered in a ring RAM until the packet ends, so the header carries the final length and status flags.

---
 rtl/ulpi_pkt_pkg.sv | 25 ++
 rtl/ulpi_pkt_dpram.sv | 18 +
 rtl/ulpi_packetizer.sv | 187 ++++++++++++++++++
 tb/tb_ulpi_packetizer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpi_pkt_pkg.sv
// Shared constants, header entry layout and FSM encodings for the ULPI packetizer.
// ULPI_PKT_TIMESTAMP_EN adds a 16-bit capture timestamp to every header.
package ulpi_pkt_pkg;
  localparam logic [3:0] MAGIC         = 4'hA;
  localparam int         FLAG_TRUNC    = 0;
  localparam int         FLAG_ERR      = 1;
  localparam int         RX_ACTIVE_BIT = 4;
  localparam int         RX_ERROR_BIT  = 5;
`ifdef ULPI_PKT_TIMESTAMP_EN
  localparam int         HDR_LEN       = 5;
`else
  localparam int         HDR_LEN       = 3;
`endif

  typedef enum logic       {C_IDLE, C_RECV}        cap_state_t;
  typedef enum logic [1:0] {O_IDLE, O_HDR, O_PAY}  out_state_t;

  typedef struct packed {
    logic [1:0]  flags;
    logic [15:0] len;
`ifdef ULPI_PKT_TIMESTAMP_EN
    logic [15:0] ts;
`endif
  } hdr_t;
endpackage

// File: rtl/ulpi_pkt_dpram.sv
// Payload ring storage: one write port, one synchronous read port.
module ulpi_pkt_dpram #(
  parameter int ADDR_W = 11
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ulpi_packetizer.sv
// Frames ULPI receive packets into length-prefixed packets for the FIFO streamer.
// ULPI_PKT_TIMESTAMP_EN: 5-byte header carrying a 16-bit start timestamp.
module ulpi_packetizer
  import ulpi_pkt_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int HDR_DEPTH_W = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA,
  input  logic       RXCMD,
  input  logic       VALID,
  output logic [7:0] OUT_DATA,
  output logic       OUT_WR,
  input  logic       HAVE_SPACE,
  output logic [7:0] DROP_CNT
);
  localparam int DEPTH = 2**HDR_DEPTH_W;
  localparam logic [ADDR_W:0] RING = {1'b1, {ADDR_W{1'b0}}};

  cap_state_t cst, cst_n;
  out_state_t ost, ost_n;
  logic [ADDR_W:0] wptr, start_wptr, rptr, crptr;
  logic [15:0] len, remain;
  logic [1:0]  flags;
  hdr_t hfifo [DEPTH];
  hdr_t cur, entry;
  logic [HDR_DEPTH_W-1:0] hwp, hrp;
  logic [HDR_DEPTH_W:0]   hcnt;
  logic [2:0]  hidx;
  logic [7:0]  rdata, obyte, hbyte;
  logic [ADDR_W-1:0] raddr;
  logic rx_active, rx_error, has_free, hfull;
  logic start, wr_en, set_trunc, set_err, push, drop;
  logic pop, emit, emit_pay, last_pay;
`ifdef ULPI_PKT_TIMESTAMP_EN
  logic [15:0] ts_cnt, ts_lat;
`endif

  assign rx_active = DATA[RX_ACTIVE_BIT];
  assign rx_error  = DATA[RX_ERROR_BIT] & DATA[RX_ACTIVE_BIT];
  assign has_free  = (wptr - crptr) != RING;
  assign hfull     = hcnt[HDR_DEPTH_W];

  // ---------------- capture side ----------------
  always_comb begin
    cst_n = cst; start = 1'b0; wr_en = 1'b0; set_trunc = 1'b0;
    set_err = 1'b0; push = 1'b0; drop = 1'b0;
    case (cst)
      C_IDLE: if (VALID && RXCMD && rx_active) begin
        start = 1'b1;
        cst_n = C_RECV;
      end
      C_RECV: if (VALID) begin
        if (!RXCMD) begin
          if (has_free) wr_en = 1'b1;
          else          set_trunc = 1'b1;
        end else if (!rx_active) begin
          cst_n = C_IDLE;
          if (hfull) drop = 1'b1;
          else       push = 1'b1;
        end else if (rx_error) set_err = 1'b1;
      end
      default: cst_n = C_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cst <= C_IDLE; wptr <= '0; start_wptr <= '0; len <= '0; flags <= '0; DROP_CNT <= '0;
    end else begin
      cst <= cst_n;
      if (start) begin start_wptr <= wptr; len <= '0; flags <= '0; end
      if (wr_en) begin wptr <= wptr + 1'b1; len <= len + 1'b1; end
      if (set_trunc) flags[FLAG_TRUNC] <= 1'b1;
      if (set_err)   flags[FLAG_ERR]   <= 1'b1;
      // a dropped packet gives its ring bytes back
      if (drop) begin
        wptr <= start_wptr;
        if (DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 1'b1;
      end
    end
  end

`ifdef ULPI_PKT_TIMESTAMP_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin ts_cnt <= '0; ts_lat <= '0; end
    else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (start) ts_lat <= ts_cnt;
    end
  end
`endif

  always_comb begin
    entry       = '0;
    entry.flags = flags;
    entry.len   = len;
`ifdef ULPI_PKT_TIMESTAMP_EN
    entry.ts    = ts_lat;
`endif
  end

  // ---------------- header FIFO ----------------
  always_ff @(posedge CLK) if (push) hfifo[hwp] <= entry;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin hwp <= '0; hcnt <= '0; end
    else begin
      if (push) hwp <= hwp + 1'b1;
      case ({push, pop})
        2'b10:   hcnt <= hcnt + 1'b1;
        2'b01:   hcnt <= hcnt - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- output side ----------------
  always_comb begin
    case (hidx)
      3'd0:    hbyte = {MAGIC, 2'b00, cur.flags};
      3'd1:    hbyte = cur.len[7:0];
      3'd2:    hbyte = cur.len[15:8];
`ifdef ULPI_PKT_TIMESTAMP_EN
      3'd3:    hbyte = cur.ts[7:0];
      3'd4:    hbyte = cur.ts[15:8];
`endif
      default: hbyte = 8'h00;
    endcase
  end

  always_comb begin
    ost_n = ost; pop = 1'b0; emit = 1'b0; emit_pay = 1'b0; last_pay = 1'b0; obyte = 8'h00;
    case (ost)
      O_IDLE: if (HAVE_SPACE && hcnt != '0) begin
        pop   = 1'b1;
        ost_n = O_HDR;
      end
      O_HDR: if (HAVE_SPACE) begin
        emit  = 1'b1;
        obyte = hbyte;
        if (hidx == 3'(HDR_LEN - 1)) ost_n = (cur.len == '0) ? O_IDLE : O_PAY;
      end
      O_PAY: if (HAVE_SPACE) begin
        emit     = 1'b1;
        emit_pay = 1'b1;
        obyte    = rdata;
        if (remain == 16'd1) begin last_pay = 1'b1; ost_n = O_IDLE; end
      end
      default: ost_n = O_IDLE;
    endcase
  end

  // rdata always holds mem[rptr]: look one ahead whenever a payload byte leaves
  assign raddr = emit_pay ? rptr[ADDR_W-1:0] + 1'b1 : rptr[ADDR_W-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ost <= O_IDLE; OUT_WR <= 1'b0; OUT_DATA <= '0; cur <= '0; hidx <= '0;
      remain <= '0; rptr <= '0; crptr <= '0; hrp <= '0;
    end else begin
      ost    <= ost_n;
      OUT_WR <= emit;
      if (emit) OUT_DATA <= obyte;
      if (pop) begin
        cur    <= hfifo[hrp];
        remain <= hfifo[hrp].len;
        hidx   <= '0;
        hrp    <= hrp + 1'b1;
      end
      if (emit && !emit_pay) hidx <= hidx + 1'b1;
      if (emit_pay) begin rptr <= rptr + 1'b1; remain <= remain - 1'b1; end
      if (last_pay) crptr <= rptr + 1'b1;
    end
  end

  ulpi_pkt_dpram #(.ADDR_W(ADDR_W)) u_ram (
    .CLK   (CLK),
    .we    (wr_en),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (DATA),
    .raddr (raddr),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_ulpi_packetizer.sv
// Self-checking bench for ulpi_packetizer: packet-level reference model against the output byte stream.
module tb_ulpi_packetizer;
  logic CLK = 1'b0, RST = 1'b1;
  logic [7:0] DATA = 8'h00;
  logic RXCMD = 1'b0, VALID = 1'b0, HAVE_SPACE = 1'b0;
  logic [7:0] OUT_DATA, DROP_CNT;
  logic OUT_WR;

  ulpi_packetizer #(.ADDR_W(11), .HDR_DEPTH_W(3)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .RXCMD(RXCMD), .VALID(VALID),
    .OUT_DATA(OUT_DATA), .OUT_WR(OUT_WR), .HAVE_SPACE(HAVE_SPACE), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  byte unsigned got[$], exp[$];
  int viol = 0;
  int hs_mode = 0;            // 0 low, 1 high, 2 toggle, 3 random
  logic hs_q = 1'b0;
  int unsigned tb_cyc = 0;
  int m_occ = 0, m_pend = 0, m_drop = 0;

  always @(posedge CLK or posedge RST)
    if (RST) begin tb_cyc <= 0; hs_q <= 1'b0; end
    else begin tb_cyc <= tb_cyc + 1; hs_q <= HAVE_SPACE; end

  always @(negedge CLK)
    if (!RST && OUT_WR) begin
      got.push_back(OUT_DATA);
      if (!hs_q) viol++;
    end

  always @(negedge CLK)
    case (hs_mode)
      0: HAVE_SPACE = 1'b0;
      1: HAVE_SPACE = 1'b1;
      2: HAVE_SPACE = ~HAVE_SPACE;
      default: HAVE_SPACE = 1'($urandom_range(1, 0));
    endcase

  task automatic drive(input logic rx, input logic [7:0] d);
    @(negedge CLK); VALID = 1'b1; RXCMD = rx; DATA = d;
  endtask

  task automatic idle();
    @(negedge CLK); VALID = 1'b0; RXCMD = 1'b0; DATA = 8'($urandom);
  endtask

  // Drives one packet and appends the bytes the host link should see to exp.
  task automatic send_pkt(input byte unsigned pay_in[$], input int err_at, input bit gaps);
    byte unsigned pay[$];
    int acc = 0, n;
    bit trunc = 0, err = 0;
    int unsigned ts;
    n = pay_in.size();
    drive(1'b1, 8'h10);
    ts = tb_cyc;
    for (int i = 0; i <= n; i++) begin
      if (gaps && $urandom_range(3, 0) == 0) idle();
      if (gaps && $urandom_range(7, 0) == 0) drive(1'b1, 8'h10 | (8'($urandom) & 8'hCF));
      if (i == err_at) begin drive(1'b1, 8'h30); err = 1; end
      if (i < n) begin
        drive(1'b0, pay_in[i]);
        if (m_occ + acc < 2048) begin pay.push_back(pay_in[i]); acc++; end
        else trunc = 1;
      end
    end
    drive(1'b1, 8'($urandom) & 8'hEF);
    idle();
    if (m_pend == 8) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
    else begin
      exp.push_back({4'hA, 2'b00, err, trunc});
      exp.push_back(acc[7:0]);
      exp.push_back(acc[15:8]);
`ifdef ULPI_PKT_TIMESTAMP_EN
      exp.push_back(ts[7:0]);
      exp.push_back(ts[15:8]);
`endif
      foreach (pay[i]) exp.push_back(pay[i]);
      m_occ += acc;
      m_pend++;
    end
  endtask

  task automatic rand_pay(input int n, output byte unsigned q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (got.size() < exp.size() && n < budget) begin @(negedge CLK); n++; end
    repeat (8) @(negedge CLK);
    m_occ = 0; m_pend = 0;
  endtask

  task automatic clear_q();
    got = {}; exp = {};
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    total++; if (OUT_WR !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", OUT_WR); end
    total++; if (OUT_DATA !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", OUT_DATA); end
    total++; if (DROP_CNT !== 8'h00) begin bad++; $display("FAIL reset_drop got=%0d exp=0", DROP_CNT); end
    total++; if (got.size() !== 0) begin bad++; $display("FAIL reset_idle_out got=%0d exp=0", got.size()); end
  endtask

  task automatic test_basic(input string nm, input int err_at);
    byte unsigned p[$];
    int nf = 0;
    clear_q();
    hs_mode = 1;
    p = '{8'h11, 8'h22, 8'h33};
    send_pkt(p, err_at, 1'b0);
    wait_drain(200);
    total++; if (got.size() !== exp.size()) begin bad++; $display("FAIL %s_len got=%0d exp=%0d", nm, got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin bad++; if (nf++ < 4) $display("FAIL %s_byte[%0d] got=%h exp=%h", nm, i, got[i], exp[i]); end
    end
    total++; if (DROP_CNT !== 8'(m_drop)) begin bad++; $display("FAIL %s_drop got=%0d exp=%0d", nm, DROP_CNT, m_drop); end
  endtask

  task automatic test_trunc();
    byte unsigned p[$];
    int nf = 0;
    clear_q();
    hs_mode = 0;
    rand_pay(2100, p);
    send_pkt(p, -1, 1'b0);
    repeat (4) @(negedge CLK);
    total++; if (got.size() !== 0) begin bad++; $display("FAIL trunc_stall got=%0d exp=0", got.size()); end
    hs_mode = 1;
    wait_drain(3000);
    total++; if (got.size() !== exp.size()) begin bad++; $display("FAIL trunc_len got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin bad++; if (nf++ < 4) $display("FAIL trunc_byte[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_drop();
    byte unsigned p[$];
    int nf = 0;
    clear_q();
    hs_mode = 0;
    for (int k = 0; k < 9; k++) begin rand_pay(1, p); send_pkt(p, -1, 1'b0); end
    total++; if (DROP_CNT !== 8'(m_drop)) begin bad++; $display("FAIL drop_cnt got=%0d exp=%0d", DROP_CNT, m_drop); end
    hs_mode = 1;
    wait_drain(500);
    rand_pay(4, p);
    send_pkt(p, -1, 1'b0);
    wait_drain(200);
    total++; if (got.size() !== exp.size()) begin bad++; $display("FAIL drop_len got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin bad++; if (nf++ < 4) $display("FAIL drop_byte[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_toggle();
    byte unsigned p[$];
    int nf = 0;
    clear_q();
    viol = 0;
    hs_mode = 0;
    for (int k = 0; k < 3; k++) begin rand_pay($urandom_range(20, 0), p); send_pkt(p, -1, 1'b0); end
    hs_mode = 2;
    wait_drain(500);
    total++; if (viol !== 0) begin bad++; $display("FAIL toggle_wr_without_space got=%0d exp=0", viol); end
    total++; if (got.size() !== exp.size()) begin bad++; $display("FAIL toggle_len got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin bad++; if (nf++ < 4) $display("FAIL toggle_byte[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    byte unsigned p[$];
    int nf = 0, npk, len;
    for (int r = 0; r < 4; r++) begin
      clear_q();
      viol = 0;
      hs_mode = 0;
      npk = $urandom_range(10, 1);
      for (int k = 0; k < npk; k++) begin
        if ($urandom_range(1, 0) == 1) drive(1'b0, 8'($urandom));
        len = $urandom_range(60, 0);
        rand_pay(len, p);
        send_pkt(p, ($urandom_range(2, 0) == 0) ? $urandom_range(len, 0) : -1, 1'b1);
      end
      hs_mode = 3;
      wait_drain(4000);
      total++; if (viol !== 0) begin bad++; $display("FAIL rand%0d_wr_without_space got=%0d exp=0", r, viol); end
      total++; if (DROP_CNT !== 8'(m_drop)) begin bad++; $display("FAIL rand%0d_drop got=%0d exp=%0d", r, DROP_CNT, m_drop); end
      total++; if (got.size() !== exp.size()) begin bad++; $display("FAIL rand%0d_len got=%0d exp=%0d", r, got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        total++;
        if (got[i] !== exp[i]) begin bad++; if (nf++ < 4) $display("FAIL rand%0d_byte[%0d] got=%h exp=%h", r, i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_rst_mid();
    byte unsigned p[$];
    int nf = 0, n = 0;
    clear_q();
    hs_mode = 1;
    rand_pay(40, p);
    send_pkt(p, -1, 1'b0);
    while (got.size() < 10 && n < 300) begin @(negedge CLK); n++; end
    total++; if (got.size() < 10) begin bad++; $display("FAIL rst_wait_output got=%0d exp>=10", got.size()); end
    total++; if (OUT_WR !== 1'b1) begin bad++; $display("FAIL rst_streaming got=%b exp=1", OUT_WR); end
    #1 RST = 1'b1;
    #1;
    total++; if (OUT_WR !== 1'b0) begin bad++; $display("FAIL rst_async_wr got=%b exp=0", OUT_WR); end
    total++; if (OUT_DATA !== 8'h00) begin bad++; $display("FAIL rst_async_data got=%h exp=00", OUT_DATA); end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    m_occ = 0; m_pend = 0; m_drop = 0;
    repeat (2) @(negedge CLK);
    clear_q();
    rand_pay(7, p);
    send_pkt(p, 3, 1'b0);
    wait_drain(200);
    total++; if (got.size() !== exp.size()) begin bad++; $display("FAIL rst_after_len got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin bad++; if (nf++ < 4) $display("FAIL rst_after_byte[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
    total++; if (DROP_CNT !== 8'h00) begin bad++; $display("FAIL rst_after_drop got=%0d exp=0", DROP_CNT); end
  endtask

  initial begin
    test_reset();
    test_basic("basic", -1);
    test_basic("err", 1);
    test_trunc();
    test_drop();
    test_toggle();
    test_random();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
